jpeg2bmp_mul_mac_pipe: RTL

- Parametrised pipelined multiplier / multiply-accumulate for the jpeg2bmp datapath (dequantisation, IDCT, colour conversion).
- Generalises the fixed 2-stage unsigned×signed multiplier in four ways:
  - configurable operand signedness and widths;
  - configurable pipeline depth;
  - valid tagging, so bubbles pass through;
  - optional per-sample accumulation with rounding right-shift and saturation.

---
 rtl/jpeg2bmp_mul_mac_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/jpeg2bmp_mul_mac_pipe.sv
// Pipelined multiplier / multiply-accumulate for the jpeg2bmp datapath.
// One sample per enabled cycle, NUM_STAGE enabled cycles of latency; the last
// stage optionally sums grouped samples, rounds, shifts and saturates.
module jpeg2bmp_mul_mac_pipe #(
  parameter int unsigned DIN0_WIDTH  = 16,
  parameter int unsigned DIN1_WIDTH  = 32,
  parameter int unsigned DOUT_WIDTH  = 32,
  parameter int unsigned NUM_STAGE   = 2,
  parameter int unsigned DIN0_SIGNED = 0,
  parameter int unsigned DIN1_SIGNED = 1,
  parameter int unsigned ACC_WIDTH   = 48,
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned SATURATE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_en,
  input  logic                  acc_first,
  input  logic                  acc_last,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_ovf
);

  // Product width holds any mix of signed/unsigned operands exactly.
  localparam int unsigned PW       = DIN0_WIDTH + DIN1_WIDTH + 1;
  // One guard bit so the rounding increment can never wrap the scaled sum.
  localparam int unsigned RW       = ACC_WIDTH + 1;
  localparam int unsigned SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [RW-1:0] RND  = (SHIFT > 0) ? (RW'(1) <<< SHIFT_M1) : '0;
  localparam logic signed [RW-1:0] MAXV = (RW'(1) <<< (DOUT_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = -(RW'(1) <<< (DOUT_WIDTH - 1));
  localparam logic [DOUT_WIDTH-1:0] DMAX = MAXV[DOUT_WIDTH-1:0];
  localparam logic [DOUT_WIDTH-1:0] DMIN = MINV[DOUT_WIDTH-1:0];

  // Operand extension: one extra bit, filled with the sign only when signed.
  logic signed [DIN0_WIDTH:0] a_ext_c;
  logic signed [DIN1_WIDTH:0] b_ext_c;
  logic signed [PW-1:0]       prod_c;

  assign a_ext_c = {(DIN0_SIGNED != 0) && din0[DIN0_WIDTH-1], din0};
  assign b_ext_c = {(DIN1_SIGNED != 0) && din1[DIN1_WIDTH-1], din1};
  assign prod_c  = PW'(a_ext_c) * PW'(b_ext_c);

  // Fields presented to the final stage.
  logic              fv_c;
  logic              fe_c;
  logic              ff_c;
  logic              fl_c;
  logic signed [PW-1:0] fp_c;

  generate
    if (NUM_STAGE == 1) begin : g_comb
      // Single-stage build: the final stage consumes the live product.
      assign fv_c = in_valid;
      assign fe_c = acc_en;
      assign ff_c = acc_first;
      assign fl_c = acc_last;
      assign fp_c = prod_c;
    end else begin : g_pipe
      localparam int NPIPE = int'(NUM_STAGE) - 1;

      logic                 vld_q   [NPIPE];
      logic                 en_q    [NPIPE];
      logic                 first_q [NPIPE];
      logic                 last_q  [NPIPE];
      logic signed [PW-1:0] prod_q  [NPIPE];

      // Delay line for the product and its tags; holds while ce is low.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < NPIPE; i++) begin
            vld_q[i]   <= 1'b0;
            en_q[i]    <= 1'b0;
            first_q[i] <= 1'b0;
            last_q[i]  <= 1'b0;
            prod_q[i]  <= '0;
          end
        end else if (ce) begin
          vld_q[0]   <= in_valid;
          en_q[0]    <= acc_en;
          first_q[0] <= acc_first;
          last_q[0]  <= acc_last;
          prod_q[0]  <= prod_c;
          for (int i = 1; i < NPIPE; i++) begin
            vld_q[i]   <= vld_q[i-1];
            en_q[i]    <= en_q[i-1];
            first_q[i] <= first_q[i-1];
            last_q[i]  <= last_q[i-1];
            prod_q[i]  <= prod_q[i-1];
          end
        end
      end

      assign fv_c = vld_q[NPIPE-1];
      assign fe_c = en_q[NPIPE-1];
      assign ff_c = first_q[NPIPE-1];
      assign fl_c = last_q[NPIPE-1];
      assign fp_c = prod_q[NPIPE-1];
    end
  endgenerate

  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic signed [ACC_WIDTH-1:0]  v_ext_c;
  logic signed [ACC_WIDTH-1:0]  sum_c;
  logic signed [ACC_WIDTH-1:0]  s_c;
  logic signed [RW-1:0]         r_c;
  logic                         ovf_c;
  logic                         out_valid_q;
  logic                         out_valid_d;
  logic [DOUT_WIDTH-1:0]        dout_q;
  logic [DOUT_WIDTH-1:0]        dout_d;
  logic                         ovf_q;

  // Final stage: accumulate, round, shift and range-limit the selected sum.
  always_comb begin
    v_ext_c     = ACC_WIDTH'(fp_c);
    sum_c       = (ff_c ? '0 : acc_q) + v_ext_c;
    s_c         = fe_c ? sum_c : v_ext_c;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    if (fv_c) begin
      out_valid_d = !fe_c || fl_c;
      if (fe_c) begin
        acc_d = sum_c;
      end
    end
    r_c   = (RW'(s_c) + RND) >>> SHIFT;
    ovf_c = (r_c > MAXV) || (r_c < MINV);
    if ((SATURATE != 0) && ovf_c) begin
      dout_d = (r_c > MAXV) ? DMAX : DMIN;
    end else begin
      dout_d = r_c[DOUT_WIDTH-1:0];
    end
  end

  // Result registers; dout/out_ovf only move when a result is emitted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (ce) begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      if (out_valid_d) begin
        dout_q <= dout_d;
        ovf_q  <= ovf_c;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_ovf   = ovf_q;

endmodule
